// File: rtl/h_eng_dispatch.sv
// Command dispatcher: input FIFO feeding ENGS_N engines round-robin with per-engine busy tracking.
// Optional issue counter (issue_cnt / stats_clr) is compiled in with H_ENG_DISPATCH_STATS_EN.
module h_eng_dispatch #(
    parameter int ENGS_N     = 4,
    parameter int CMD_W      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [CMD_W-1:0]  in_cmd,
    output logic [ENGS_N-1:0] eng_vld,
    output logic [CMD_W-1:0]  eng_cmd,
    input  logic [ENGS_N-1:0] eng_rdy,
    input  logic [ENGS_N-1:0] eng_done,
    output logic [ENGS_N-1:0] eng_busy,
    output logic              idle,
`ifdef H_ENG_DISPATCH_STATS_EN
    input  logic              stats_clr,
    output logic [31:0]       issue_cnt,
`endif
    output logic              err_done
);

    localparam int ENG_W = (ENGS_N > 1) ? $clog2(ENGS_N) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t              state_q;
    logic [CMD_W-1:0]    fifo_mem_q [FIFO_DEPTH];
    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic                in_rdy_q;
    logic [ENGS_N-1:0]   eng_vld_q;
    logic [CMD_W-1:0]    eng_cmd_q;
    logic [ENG_W-1:0]    tgt_q;
    logic [ENG_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ENGS_N-1:0]   eng_busy_q, eng_busy_d;
    logic                idle_q, idle_d;
    logic                err_done_q, err_done_d;

    logic                push_s, load_s, hs_s, empty_s, empty_d_s, full_d_s;
    logic [ENGS_N-1:0]   free_s, sel_oh_s, vld_next_s;
    logic [ENG_W-1:0]    sel_idx_s;
    logic                sel_found_s;
    logic [CMD_W-1:0]    head_s;

    assign in_rdy   = in_rdy_q;
    assign eng_vld  = eng_vld_q;
    assign eng_cmd  = eng_cmd_q;
    assign eng_busy = eng_busy_q;
    assign idle     = idle_q;
    assign err_done = err_done_q;

    // Handshake, FIFO pointer and status next-state logic.
    always_comb begin
        push_s     = in_vld & in_rdy_q;
        empty_s    = (wr_ptr_q == rd_ptr_q);
        head_s     = fifo_mem_q[rd_ptr_q[AW-1:0]];
        hs_s       = (state_q == ST_ISSUE) && ((eng_vld_q & eng_rdy) != '0);
        load_s     = !empty_s && sel_found_s && ((state_q == ST_IDLE) || hs_s);
        wr_ptr_d   = push_s ? (wr_ptr_q + {{AW{1'b0}}, 1'b1}) : wr_ptr_q;
        rd_ptr_d   = load_s ? (rd_ptr_q + {{AW{1'b0}}, 1'b1}) : rd_ptr_q;
        full_d_s   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        empty_d_s  = (wr_ptr_d == rd_ptr_d);
        vld_next_s = load_s ? sel_oh_s : (hs_s ? '0 : eng_vld_q);
        eng_busy_d = (eng_busy_q & ~eng_done) | (hs_s ? eng_vld_q : '0);
        err_done_d = err_done_q | ((eng_done & ~eng_busy_q) != '0);
        idle_d     = empty_d_s && (vld_next_s == '0) && (eng_busy_d == '0);
        rr_ptr_d   = hs_s ? ((tgt_q == ENG_W'(ENGS_N - 1)) ? '0 : (tgt_q + {{(ENG_W-1){1'b0}}, 1'b1}))
                          : rr_ptr_q;
    end

    // Round-robin pick: first free engine at or after rr_ptr, never the pending target.
    always_comb begin
        free_s      = ~eng_busy_q & ~eng_vld_q;
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        sel_oh_s    = '0;
        for (int off = 0; off < ENGS_N; off++) begin
            int sum_v;
            int cand_v;
            sum_v  = int'(rr_ptr_q) + off;
            cand_v = (sum_v >= ENGS_N) ? (sum_v - ENGS_N) : sum_v;
            if (!sel_found_s && free_s[cand_v]) begin
                sel_found_s      = 1'b1;
                sel_idx_s        = ENG_W'(cand_v);
                sel_oh_s[cand_v] = 1'b1;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // FIFO storage; entries need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= in_cmd;
        end
    end

    // FIFO pointers, busy tracking and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            in_rdy_q   <= 1'b0;
            rr_ptr_q   <= '0;
            eng_busy_q <= '0;
            idle_q     <= 1'b1;
            err_done_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            in_rdy_q   <= !full_d_s;
            rr_ptr_q   <= rr_ptr_d;
            eng_busy_q <= eng_busy_d;
            idle_q     <= idle_d;
            err_done_q <= err_done_d;
        end
    end

    // Issue FSM: holds eng_vld/eng_cmd until the target accepts, reloading back-to-back when possible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            eng_vld_q <= '0;
            eng_cmd_q <= '0;
            tgt_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_s) begin
                        eng_vld_q <= sel_oh_s;
                        eng_cmd_q <= head_s;
                        tgt_q     <= sel_idx_s;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (hs_s) begin
                        if (load_s) begin
                            eng_vld_q <= sel_oh_s;
                            eng_cmd_q <= head_s;
                            tgt_q     <= sel_idx_s;
                        end else begin
                            eng_vld_q <= '0;
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    eng_vld_q <= '0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef H_ENG_DISPATCH_STATS_EN
    logic [31:0] issue_cnt_q;

    assign issue_cnt = issue_cnt_q;

    // Completed-issue counter; a clear coinciding with a handshake leaves one.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_q <= 32'd0;
        end else if (stats_clr) begin
            issue_cnt_q <= hs_s ? 32'd1 : 32'd0;
        end else if (hs_s) begin
            issue_cnt_q <= issue_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_h_eng_dispatch.sv
// Directed bench for h_eng_dispatch: round-robin issue, FIFO backpressure, stalls, err_done and reset.
module tb_h_eng_dispatch;

    logic        clk;
    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    logic [31:0] in_cmd;
    logic [3:0]  eng_vld;
    logic [31:0] eng_cmd;
    logic [3:0]  eng_rdy;
    logic [3:0]  eng_done;
    logic [3:0]  eng_busy;
    logic        idle;
    logic        err_done;
`ifdef H_ENG_DISPATCH_STATS_EN
    logic        stats_clr;
    logic [31:0] issue_cnt;
`endif

    int n_pass = 0;
    int n_total = 0;

    h_eng_dispatch #(.ENGS_N(4), .CMD_W(32), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_cmd   (in_cmd),
        .eng_vld  (eng_vld),
        .eng_cmd  (eng_cmd),
        .eng_rdy  (eng_rdy),
        .eng_done (eng_done),
        .eng_busy (eng_busy),
        .idle     (idle),
`ifdef H_ENG_DISPATCH_STATS_EN
        .stats_clr(stats_clr),
        .issue_cnt(issue_cnt),
`endif
        .err_done (err_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_vld   = 1'b0;
        in_cmd   = 32'h0;
        eng_rdy  = 4'h0;
        eng_done = 4'h0;
`ifdef H_ENG_DISPATCH_STATS_EN
        stats_clr = 1'b0;
`endif
        tick();
        tick();
        chk("rst_in_rdy", in_rdy, 64'h0);
        chk("rst_vld", eng_vld, 64'h0);
        chk("rst_cmd", eng_cmd, 64'h0);
        chk("rst_busy", eng_busy, 64'h0);
        chk("rst_idle", idle, 64'h1);
        chk("rst_err", err_done, 64'h0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_rdy", in_rdy, 64'h1);

        // Four commands issued to engines 0..3 on consecutive cycles
        eng_rdy = 4'hF;
        in_vld = 1'b1; in_cmd = 32'hA0; tick();
        chk("t1_vld_lat", eng_vld, 64'h0);
        in_cmd = 32'hA1; tick();
        chk("t1_vld0", eng_vld, 64'h1);
        chk("t1_cmd0", eng_cmd, 64'hA0);
        in_cmd = 32'hA2; tick();
        chk("t1_vld1", eng_vld, 64'h2);
        chk("t1_cmd1", eng_cmd, 64'hA1);
        in_cmd = 32'hA3; tick();
        chk("t1_vld2", eng_vld, 64'h4);
        chk("t1_cmd2", eng_cmd, 64'hA2);
        in_vld = 1'b0; tick();
        chk("t1_vld3", eng_vld, 64'h8);
        chk("t1_cmd3", eng_cmd, 64'hA3);
        tick();
        chk("t1_busy", eng_busy, 64'hF);
        chk("t1_vld_off", eng_vld, 64'h0);
        chk("t1_idle", idle, 64'h0);

        // FIFO fills with all engines busy; fifth command is refused
        in_vld = 1'b1;
        in_cmd = 32'hB0; tick();
        in_cmd = 32'hB1; tick();
        in_cmd = 32'hB2; tick();
        chk("t2_rdy_3", in_rdy, 64'h1);
        in_cmd = 32'hB3; tick();
        chk("t2_full", in_rdy, 64'h0);
        in_cmd = 32'hB4; tick();
        chk("t2_full_hold", in_rdy, 64'h0);
        chk("t2_no_issue", eng_vld, 64'h0);
        in_vld = 1'b0;
        eng_done = 4'b0100; tick();
        eng_done = 4'h0;
        chk("t2_busy_clr", eng_busy, 64'hB);
        chk("t2_vld_wait", eng_vld, 64'h0);
        tick();
        chk("t2_vld_e2", eng_vld, 64'h4);
        chk("t2_cmd_b0", eng_cmd, 64'hB0);
        chk("t2_rdy_back", in_rdy, 64'h1);
        tick();
        chk("t2_busy_f", eng_busy, 64'hF);
        chk("t2_vld_off", eng_vld, 64'h0);

        // Round-robin: issue to engine 1 leaves rr_ptr=2, so 3 wins over 0
        eng_done = 4'b0010; tick();
        eng_done = 4'h0; tick();
        chk("t3_vld_e1", eng_vld, 64'h2);
        chk("t3_cmd_b1", eng_cmd, 64'hB1);
        tick();
        chk("t3_busy_f", eng_busy, 64'hF);
        eng_done = 4'b1001; tick();
        eng_done = 4'h0; tick();
        chk("t3_vld_e3", eng_vld, 64'h8);
        chk("t3_cmd_b2", eng_cmd, 64'hB2);

        // Engine 0 stalls for five cycles; payload must stay put
        eng_rdy = 4'b1110; tick();
        chk("t3_vld_e0", eng_vld, 64'h1);
        chk("t3_cmd_b3", eng_cmd, 64'hB3);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_vld", eng_vld, 64'h1);
            chk("t4_hold_cmd", eng_cmd, 64'hB3);
            chk("t4_hold_busy", eng_busy, 64'hE);
            tick();
        end
        eng_rdy = 4'hF; tick();
        chk("t4_busy_f", eng_busy, 64'hF);
        chk("t4_vld_off", eng_vld, 64'h0);
        tick();
        chk("t4_no_dup", eng_vld, 64'h0);

        // Done on an idle engine sets sticky err_done
        eng_done = 4'b0010; tick();
        chk("t5_busy_d", eng_busy, 64'hD);
        chk("t5_err_clean", err_done, 64'h0);
        tick();
        chk("t5_err_set", err_done, 64'h1);
        chk("t5_busy_same", eng_busy, 64'hD);
        eng_done = 4'h0; tick();
        chk("t5_err_sticky", err_done, 64'h1);
        chk("t5_not_idle", idle, 64'h0);
        eng_done = 4'b1101; tick();
        eng_done = 4'h0;
        chk("t5_idle", idle, 64'h1);
        chk("t5_busy_0", eng_busy, 64'h0);
        tick();
        chk("t5_err_keep", err_done, 64'h1);

        // Reset mid-ISSUE with three entries queued
        eng_rdy = 4'h0;
        in_vld = 1'b1;
        in_cmd = 32'hC0; tick();
        in_cmd = 32'hC1; tick();
        chk("t6_vld_e1", eng_vld, 64'h2);
        chk("t6_cmd_c0", eng_cmd, 64'hC0);
        in_cmd = 32'hC2; tick();
        in_cmd = 32'hC3; tick();
        in_vld = 1'b0;
        chk("t6_rdy_3q", in_rdy, 64'h1);
        chk("t6_not_idle", idle, 64'h0);
        rst = 1'b1; tick();
        chk("t6_vld", eng_vld, 64'h0);
        chk("t6_busy", eng_busy, 64'h0);
        chk("t6_idle", idle, 64'h1);
        chk("t6_err", err_done, 64'h0);
        chk("t6_in_rdy", in_rdy, 64'h0);
`ifdef H_ENG_DISPATCH_STATS_EN
        chk("t6_cnt", issue_cnt, 64'h0);
`endif
        rst = 1'b0;
        eng_rdy = 4'hF;
        tick();
        chk("t6_rdy_back", in_rdy, 64'h1);
        tick();
        tick();
        chk("t6_fifo_gone", eng_vld, 64'h0);
        chk("t6_idle_kept", idle, 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
